// File: rtl/mem_pkg.sv
// mem_pkg: access-type encodings, line geometry and lane-enable helper for data_mem_bram
//   MEM_BYTE/MEM_HALF/MEM_WORD/MEM_RSVD  mem_type encodings
//   LINE_WORDS                           words per cache line
//   mem_type_t                           2-bit access type
//   byte_en(t, a)                        4-bit lane enable for a write of type t at byte offset a
package mem_pkg;
    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;
    localparam logic [1:0] MEM_RSVD = 2'b11;
    localparam int LINE_WORDS = 4;
    typedef logic [1:0] mem_type_t;
    function automatic logic [3:0] byte_en(input mem_type_t t, input logic [1:0] a);
        return t == MEM_BYTE ? 4'b0001 << a :
               t == MEM_HALF ? 4'b0011 << {a[1], 1'b0} : 4'b1111;
    endfunction
endpackage

// File: rtl/line_burst_monitor.sv
// line_burst_monitor: counts completed in-order 4-word line bursts in one direction
//   clk        in   rising-edge clock
//   rst_n      in   async active-low reset
//   en         in   access in this monitor's direction this cycle
//   ok         in   access is legal (in range and, for writes, aligned)
//   word_addr  in   mem_addr[31:2]; [29:2] is the line tag, [1:0] the word offset
//   count      out  saturating count of completed bursts
module line_burst_monitor
    import mem_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 ok,
    input  logic [29:0]          word_addr,
    output logic [CNT_WIDTH-1:0] count
);
    localparam logic [1:0] LAST = 2'(LINE_WORDS - 1);
    logic [27:0] tag;
    logic [1:0]  seq;
    logic [1:0]  k;
    logic        hit;
    assign k   = word_addr[1:0];
    assign hit = word_addr[29:2] == tag;
    // seq holds the next expected word offset; offset 0 always (re)starts a burst
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag   <= '0;
            seq   <= '0;
            count <= '0;
        end else if (!(en && ok)) begin
            seq <= '0;
        end else if (k == LAST && seq == LAST && hit) begin
            seq <= '0;
            if (count != '1) count <= count + 1'b1;
        end else if (k == 2'd0) begin
            tag <= word_addr[29:2];
            seq <= 2'd1;
        end else begin
            seq <= (k == seq && hit) ? k + 2'd1 : 2'd0;
        end
    end
endmodule

// File: rtl/data_mem_bram.sv
// data_mem_bram: word-organised data memory behind the cache controller, 1-cycle read-first BRAM
module data_mem_bram
  import mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 131072,
  parameter string       INIT_FILE   = "",
  parameter int          CNT_WIDTH   = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          mem_addr,
  input  logic [31:0]          mem_wdata,
  input  logic                 mem_write_en,
  input  mem_type_t            mem_type,
  output logic [31:0]          mem_rdata,
  output logic [CNT_WIDTH-1:0] line_fills,
  output logic [CNT_WIDTH-1:0] line_evicts,
  output logic                 err_range,
  output logic                 err_align
);
  localparam int AW = $clog2(DEPTH_WORDS);
  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   off;
  logic [AW-1:0] idx;
  logic          in_range;
  logic          aligned;
  logic          wr_ok;
  logic [3:0]    be;
  assign off      = mem_addr - BASE_ADDR;
  assign idx      = off[AW+1:2];
  assign in_range = mem_addr >= BASE_ADDR && {2'b00, off[31:2]} < 32'(DEPTH_WORDS);
  assign aligned  = mem_type == MEM_BYTE ? 1'b1 :
                    mem_type == MEM_HALF ? !mem_addr[0] :
                    mem_type == MEM_WORD ? mem_addr[1:0] == 2'b00 : 1'b0;
  assign wr_ok    = mem_write_en && in_range && aligned;
  assign be       = byte_en(mem_type, mem_addr[1:0]);
  always_ff @(posedge clk) begin
    if (wr_ok)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i+:8] <= mem_wdata[8*i+:8];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rdata <= '0;
      err_range <= 1'b0;
      err_align <= 1'b0;
    end else begin
      mem_rdata <= in_range ? mem[idx] : 32'h0;
      err_range <= err_range | !in_range;
      err_align <= err_align | (mem_write_en && !aligned);
    end
  end
  line_burst_monitor #(.CNT_WIDTH(CNT_WIDTH)) u_rd_mon (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (!mem_write_en),
    .ok        (in_range),
    .word_addr (mem_addr[31:2]),
    .count     (line_fills)
  );
  line_burst_monitor #(.CNT_WIDTH(CNT_WIDTH)) u_wr_mon (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (mem_write_en),
    .ok        (in_range && aligned),
    .word_addr (mem_addr[31:2]),
    .count     (line_evicts)
  );
endmodule

// File: tb/tb_data_mem_bram.sv
// tb_data_mem_bram: directed scoreboard bench for data_mem_bram
module tb_data_mem_bram;
    localparam int DEPTH = 131072;
    localparam int CW    = 2;
    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [31:0]   mem_addr = '0;
    logic [31:0]   mem_wdata = '0;
    logic          mem_write_en = 1'b0;
    logic [1:0]    mem_type = 2'b10;
    logic [31:0]   mem_rdata;
    logic [CW-1:0] line_fills;
    logic [CW-1:0] line_evicts;
    logic          err_range;
    logic          err_align;
    int            n_vec = 0;
    int            n_bad = 0;
    typedef struct packed {
        logic [31:0] v;
        logic        known;
    } sb_t;
    sb_t         sb [$];
    logic [31:0] model [int unsigned];

    data_mem_bram #(.DEPTH_WORDS(DEPTH), .CNT_WIDTH(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_write_en (mem_write_en),
        .mem_type     (mem_type),
        .mem_rdata    (mem_rdata),
        .line_fills   (line_fills),
        .line_evicts  (line_evicts),
        .err_range    (err_range),
        .err_align    (err_align)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // one access per cycle; expected read word pushed at drive, popped after the edge
    task automatic step(input logic [31:0] a, input logic [31:0] d, input logic we, input logic [1:0] t);
        sb_t          e;
        sb_t          g;
        int unsigned  w;
        logic         ir;
        logic         al;
        logic [3:0]   be;
        logic [31:0]  tmp;
        mem_addr     = a;
        mem_wdata    = d;
        mem_write_en = we;
        mem_type     = t;
        ir = a < 32'(4 * DEPTH);
        w  = a >> 2;
        e.known = !ir || model.exists(w);
        e.v     = (ir && model.exists(w)) ? model[w] : 32'h0;
        sb.push_back(e);
        al = t == 2'b00 ? 1'b1 : t == 2'b01 ? !a[0] : t == 2'b10 ? a[1:0] == 2'b00 : 1'b0;
        be = t == 2'b00 ? 4'b0001 << a[1:0] : t == 2'b01 ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        if (we && ir && al) begin
            if (be == 4'hF) model[w] = d;
            else if (model.exists(w)) begin
                tmp = model[w];
                for (int i = 0; i < 4; i++) if (be[i]) tmp[8*i+:8] = d[8*i+:8];
                model[w] = tmp;
            end
        end
        @(posedge clk);
        #1;
        g = sb.pop_front();
        if (g.known) chk("rdata", mem_rdata, g.v);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rdata", mem_rdata, 32'h0);
        chk("rst_fills", 32'(line_fills), 32'h0);
        chk("rst_evicts", 32'(line_evicts), 32'h0);
        chk("rst_errs", {30'h0, err_range, err_align}, 32'h0);
        rst_n = 1'b1;
        // word write then read
        step(32'h100, 32'hDEADBEEF, 1'b1, 2'b10);
        step(32'h100, 32'h0, 1'b0, 2'b10);
        chk("t1_errs", {30'h0, err_range, err_align}, 32'h0);
        // byte and half merges; write cycle returns the old word
        step(32'h100, 32'h11223344, 1'b1, 2'b10);
        step(32'h103, 32'hAA000000, 1'b1, 2'b00);
        step(32'h100, 32'h0, 1'b0, 2'b10);
        chk("t2_byte", model[32'h40], 32'hAA223344);
        step(32'h102, 32'h55660000, 1'b1, 2'b01);
        step(32'h100, 32'h0, 1'b0, 2'b10);
        // out-of-order writes must not count as an eviction burst
        step(32'h204, 32'hA0000001, 1'b1, 2'b10);
        step(32'h208, 32'hA0000002, 1'b1, 2'b10);
        step(32'h20C, 32'hA0000003, 1'b1, 2'b10);
        step(32'h200, 32'hA0000000, 1'b1, 2'b10);
        chk("t3_evicts0", 32'(line_evicts), 32'h0);
        step(32'h200, 32'h0, 1'b0, 2'b10);
        step(32'h204, 32'h0, 1'b0, 2'b10);
        step(32'h208, 32'h0, 1'b0, 2'b10);
        chk("t3_fills0", 32'(line_fills), 32'h0);
        step(32'h20C, 32'h0, 1'b0, 2'b10);
        chk("t3_fills1", 32'(line_fills), 32'h1);
        // writeback burst, then a broken read burst
        for (int i = 0; i < 4; i++) step(32'h300 + 32'(4 * i), 32'hB0000000 + 32'(i), 1'b1, 2'b10);
        chk("t4_evicts", 32'(line_evicts), 32'h1);
        step(32'h400, 32'h0, 1'b0, 2'b10);
        step(32'h404, 32'h0, 1'b0, 2'b10);
        step(32'h100, 32'h0, 1'b0, 2'b10);
        step(32'h40C, 32'h0, 1'b0, 2'b10);
        chk("t4_fills", 32'(line_fills), 32'h1);
        chk("t4_evicts2", 32'(line_evicts), 32'h1);
        // illegal writes leave memory untouched
        step(32'h102, 32'hCAFEF00D, 1'b1, 2'b10);
        chk("t5_align", 32'(err_align), 32'h1);
        chk("t5_range0", 32'(err_range), 32'h0);
        step(32'h101, 32'hCAFEF00D, 1'b1, 2'b01);
        step(32'h100, 32'hCAFEF00D, 1'b1, 2'b11);
        step(32'h100, 32'h0, 1'b0, 2'b10);
        step(32'(4 * DEPTH - 4), 32'h0BADCAFE, 1'b1, 2'b10);
        step(32'(4 * DEPTH - 4), 32'h0, 1'b0, 2'b10);
        chk("t5_top_word", 32'(err_range), 32'h0);
        step(32'(4 * DEPTH), 32'h12345678, 1'b1, 2'b10);
        step(32'(4 * DEPTH), 32'h0, 1'b0, 2'b10);
        chk("t5_range1", 32'(err_range), 32'h1);
        // reset mid-burst
        step(32'h200, 32'h0, 1'b0, 2'b10);
        step(32'h204, 32'h0, 1'b0, 2'b10);
        rst_n = 1'b0;
        #1;
        chk("t6_rdata", mem_rdata, 32'h0);
        chk("t6_fills", 32'(line_fills), 32'h0);
        chk("t6_evicts", 32'(line_evicts), 32'h0);
        chk("t6_errs", {30'h0, err_range, err_align}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(32'h100, 32'h0, 1'b0, 2'b10);
        for (int i = 0; i < 4; i++) step(32'h200 + 32'(4 * i), 32'h0, 1'b0, 2'b10);
        chk("t6_fresh", 32'(line_fills), 32'h1);
        // counter saturates instead of wrapping
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 4; i++) step(32'h300 + 32'(4 * i), 32'h0, 1'b0, 2'b10);
            chk("sat_fills", 32'(line_fills), b == 0 ? 32'h2 : 32'h3);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
